sub_result_stage: RTL and testbench
===================================

// Module: sub_result_stage
// PURPOSE
//  Registered output stage directly downstream of the 6-bit signed ripple subtracter.
//  - Captures the raw difference plus the operand sign bits.
//  - Flags two's-complement overflow and optionally saturates the result.
//  - Buffers results in a 2-entry skid buffer with valid/ready handshake on both sides.
//  - Keeps a running count of overflow events for debug/status.
// PARAMETERS
//  W     6  data width; must match the subtracter width.
//  CW    8  overflow-counter width.
// PORTS
//  Clk        in   1   single clock, rising edge
//  Reset      in   1   asynchronous, active-low; clears all state
//  In_Valid   in   1   Diff/A_Sign/B_Sign are valid this cycle
//  In_Ready   out  1   stage can accept; high when buffer holds fewer than 2 entries
//  Diff       in   W   raw difference from subtracter (A-B mod 2^W)
//  A_Sign     in   1   A[W-1]
//  B_Sign     in   1   B[W-1]
//  Out_Valid  out  1   head entry valid
//  Out_Ready  in   1   consumer accepts head this cycle
//  Out_Diff   out  W   head result (raw or saturated)
//  Out_Ovf    out  1   head entry overflowed
//  Ovf_Count  out  CW  accepted overflow events, saturating
// BEHAVIOUR
//  - Reset (async, active-low) takes effect immediately, mid-transfer included; buffer contents are discarded.
//    Reset values: In_Ready=1, Out_Valid=0, Out_Diff=0, Out_Ovf=0, Ovf_Count=0.
//  - Push = In_Valid & In_Ready.
//  - Pop = Out_Valid & Out_Ready.
//  - Overflow: ovf = (A_Sign != B_Sign) & (Diff[W-1] != A_Sign). Evaluated at push and stored with the entry.
//  - FSM states (buffer occupancy): EMPTY, ONE, FULL.
//    EMPTY: push -> ONE.
//    ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE (head replaced by new entry).
//    FULL: pop -> ONE (second entry promoted to head); push impossible because In_Ready=0.
//  - Latency: an entry pushed at edge t is visible on Out_* after edge t, i.e. Out_Valid high in cycle t+1.
//  - In_Ready = (state != FULL). It is a registered function of state and does not combinationally depend on Out_Ready.
//  - Out_Diff/Out_Ovf hold their value while Out_Valid=1 and Out_Ready=0; order is strictly FIFO.
//  - Ovf_Count increments on every push with ovf=1 and saturates at 2^CW-1 (no wrap).
//  - Arithmetic: no sign extension; all results stay W bits.
// CONFIGURATION
//  Macro SUB_RESULT_SATURATE_EN:
//  - Defined: on ovf, stored Diff is clamped. A_Sign=0 -> 0 followed by W-1 ones (+2^(W-1)-1); A_Sign=1 -> 1 followed by W-1 zeros (-2^(W-1)).
//  - Undefined: Diff stored unmodified (wrap-around). Out_Ovf and Ovf_Count behave identically in both builds.
// STRUCTURE
//  - Shared package sub_pkg: SUB_W=6 constant and the buffer-state enum {EMPTY, ONE, FULL}.
//  - One sub-module: sub_ovf_detect (combinational). Inputs Diff, A_Sign, B_Sign; outputs ovf and the clamped/raw value.
//  - The buffer and FSM live in this module.
// TESTING
//  1. Normal subtraction: A=5, B=9 -> Diff=6'b111100, signs 0/0. Out_Diff=6'b111100 (-4), Out_Ovf=0, Out_Valid one cycle after push.
//  2. Positive overflow: A=20, B=-15 -> Diff=6'b100011, A_Sign=0, B_Sign=1. Out_Ovf=1, Ovf_Count=1.
//     Out_Diff=6'b011111 with SUB_RESULT_SATURATE_EN; 6'b100011 without.
//  3. Negative overflow: A=-20, B=15 -> Diff=6'b011101, A_Sign=1, B_Sign=0. Out_Ovf=1.
//     Out_Diff=6'b100000 saturated; 6'b011101 raw.
//  4. Backpressure: Out_Ready=0, push 3 back-to-back values. In_Ready drops after the 2nd push.
//     The 3rd is held off; raising Out_Ready drains the 2 entries in order, then the 3rd is accepted.
//  5. Simultaneous push/pop in ONE: Out_Ready=1, In_Valid=1 every cycle for 10 cycles.
//     Throughput 1/cycle, In_Ready stays 1, outputs in order.
//  6. Async reset mid-operation: assert Reset low while FULL, between clock edges.
//     Out_Valid=0, Ovf_Count=0, In_Ready=1 immediately; no stale entry after release.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the subtracter result stage: data width and
// the occupancy states of the two-entry output buffer.
package sub_pkg;

    localparam int SUB_W = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/sub_ovf_detect.sv
// Two's-complement overflow detection for a W-bit difference A-B, plus the
// value to store for that difference.
// Build option: SUB_RESULT_SATURATE_EN clamps overflowed results to the
// W-bit signed limit in the direction of the true result; without it the
// wrapped difference passes through unchanged.
module sub_ovf_detect
    import sub_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic [W-1:0] Diff,
    input  logic         A_Sign,
    input  logic         B_Sign,
    output logic         ovf,
    output logic [W-1:0] result
);

    // Overflow only when operand signs differ and the result sign disagrees with A.
    always_comb begin
        ovf    = (A_Sign != B_Sign) && (Diff[W-1] != A_Sign);
        result = Diff;
`ifdef SUB_RESULT_SATURATE_EN
        if (ovf) begin
            result = A_Sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/sub_result_stage.sv
// Registered output stage behind the ripple subtracter. Tags each result with
// an overflow flag, holds up to two results in a skid buffer with valid/ready
// on both sides, and counts overflow events (saturating).
// Build option: SUB_RESULT_SATURATE_EN (see sub_ovf_detect) selects clamped
// rather than wrapped storage of overflowed differences.
//
//  state | meaning
//  EMPTY | no entry held; Out_Valid low
//  ONE   | head entry on Out_*; skid slot free
//  FULL  | head on Out_*, second entry in skid slot; In_Ready low
module sub_result_stage
    import sub_pkg::*;
#(
    parameter int W  = SUB_W,
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [W-1:0]  Diff,
    input  logic          A_Sign,
    input  logic          B_Sign,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic [W-1:0]  Out_Diff,
    output logic          Out_Ovf,
    output logic [CW-1:0] Ovf_Count
);

    buf_state_t   state;
    logic [W-1:0] skid_diff;
    logic         skid_ovf;
    logic         new_ovf;
    logic [W-1:0] new_diff;
    logic         push;
    logic         pop;

    sub_ovf_detect #(.W(W)) u_ovf_detect (
        .Diff   (Diff),
        .A_Sign (A_Sign),
        .B_Sign (B_Sign),
        .ovf    (new_ovf),
        .result (new_diff)
    );

    assign push = In_Valid && In_Ready;
    assign pop  = Out_Valid && Out_Ready;

    // Occupancy FSM; head and handshake outputs are registered alongside the state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= EMPTY;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Out_Diff  <= '0;
            Out_Ovf   <= 1'b0;
            skid_diff <= '0;
            skid_ovf  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        Out_Diff  <= new_diff;
                        Out_Ovf   <= new_ovf;
                        Out_Valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_diff <= new_diff;
                        skid_ovf  <= new_ovf;
                        In_Ready  <= 1'b0;
                        state     <= FULL;
                    end else if (pop && !push) begin
                        Out_Valid <= 1'b0;
                        state     <= EMPTY;
                    end else if (push && pop) begin
                        Out_Diff <= new_diff;
                        Out_Ovf  <= new_ovf;
                    end
                end
                FULL: begin
                    // In_Ready is low here, so only a pop can happen.
                    if (pop) begin
                        Out_Diff <= skid_diff;
                        Out_Ovf  <= skid_ovf;
                        In_Ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    In_Ready  <= 1'b1;
                    Out_Valid <= 1'b0;
                end
            endcase
        end
    end

    // Count accepted overflowed entries, sticking at all-ones.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Ovf_Count <= '0;
        end else if (push && new_ovf && (Ovf_Count != {CW{1'b1}})) begin
            Ovf_Count <= Ovf_Count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub_result_stage.sv
module tb_sub_result_stage;

    localparam int W  = 6;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          In_Valid;
    logic          In_Ready;
    logic [W-1:0]  Diff;
    logic          A_Sign;
    logic          B_Sign;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [W-1:0]  Out_Diff;
    logic          Out_Ovf;
    logic [CW-1:0] Ovf_Count;

    sub_result_stage #(.W(W), .CW(CW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Diff      (Diff),
        .A_Sign    (A_Sign),
        .B_Sign    (B_Sign),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Diff  (Out_Diff),
        .Out_Ovf   (Out_Ovf),
        .Ovf_Count (Ovf_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] d;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    int   stalls = 0;
    bit   rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true signed difference, overflow when it leaves the W-bit range.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   t;
        int   lo;
        int   hi;
        t   = a - b;
        hi  = (1 << (W - 1)) - 1;
        lo  = -(1 << (W - 1));
        e.o = (t > hi) || (t < lo);
        e.d = W'(t);
`ifdef SUB_RESULT_SATURATE_EN
        if (t > hi) e.d = W'(hi);
        if (t < lo) e.d = W'(lo);
`endif
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push_ab(input int a, input int b);
        exp_t e;
        int   t;
        int   waited;
        t        = a - b;
        e        = model(a, b);
        Diff     = W'(t);
        A_Sign   = (a < 0);
        B_Sign   = (b < 0);
        In_Valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge Clk);
            if (In_Ready) break;
            waited++;
            if (waited > 50) begin
                chk("push_timeout", 32'd0, 32'd1);
                In_Valid = 1'b0;
                return;
            end
            @(posedge Clk);
            #1;
        end
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (e.o && exp_count < CNT_MAX) exp_count++;
        In_Valid = 1'b0;
        stalls += waited;
    endtask

    task automatic drain();
        Out_Ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge Clk);
            #1;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    // Monitor: compare every accepted output against the scoreboard head.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset === 1'b1 && Out_Valid && Out_Ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_diff", 32'(Out_Diff), 32'(e.d));
                chk("out_ovf", 32'(Out_Ovf), 32'(e.o));
                chk("ovf_count", 32'(Ovf_Count), 32'(exp_count));
            end
        end
    end

    always @(posedge Clk) begin
        if (rand_ready) begin
            #1;
            Out_Ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        exp_t e;
        Reset     = 1'b0;
        In_Valid  = 1'b0;
        Diff      = '0;
        A_Sign    = 1'b0;
        B_Sign    = 1'b0;
        Out_Ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_out_diff", 32'(Out_Diff), 32'd0);
        chk("rst_out_ovf", 32'(Out_Ovf), 32'd0);
        chk("rst_ovf_count", 32'(Ovf_Count), 32'd0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Normal subtraction, one-cycle latency
        push_ab(5, 9);
        chk("t1_latency_valid", 32'(Out_Valid), 32'd1);
        chk("t1_diff", 32'(Out_Diff), 32'h3c);
        chk("t1_ovf", 32'(Out_Ovf), 32'd0);
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        chk("t1_empty_after_pop", 32'(Out_Valid), 32'd0);

        // Positive overflow
        push_ab(20, -15);
        e = model(20, -15);
        chk("t2_ovf", 32'(Out_Ovf), 32'd1);
        chk("t2_count", 32'(Ovf_Count), 32'd1);
`ifdef SUB_RESULT_SATURATE_EN
        chk("t2_diff", 32'(Out_Diff), 32'h1f);
`else
        chk("t2_diff", 32'(Out_Diff), 32'h23);
`endif

        // Negative overflow
        push_ab(-20, 15);
        chk("t3_ovf", 32'(Out_Ovf), 32'd1);
        chk("t3_count", 32'(Ovf_Count), 32'd2);
`ifdef SUB_RESULT_SATURATE_EN
        chk("t3_diff", 32'(Out_Diff), 32'h20);
`else
        chk("t3_diff", 32'(Out_Diff), 32'h1d);
`endif
        repeat (2) @(posedge Clk);
        #1;

        // Backpressure: third push held off until the buffer drains
        Out_Ready = 1'b0;
        push_ab(1, 2);
        chk("t4_ready_after_1", 32'(In_Ready), 32'd1);
        push_ab(3, 4);
        chk("t4_ready_after_2", 32'(In_Ready), 32'd0);
        fork
            push_ab(7, 1);
            begin
                repeat (3) @(posedge Clk);
                #1;
                chk("t4_hold_diff", 32'(Out_Diff), 32'h3f);
                chk("t4_hold_ready", 32'(In_Ready), 32'd0);
                Out_Ready = 1'b1;
            end
        join
        drain();

        // Streaming: push and pop every cycle
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            push_ab(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
        end
        chk("t5_no_stalls", stalls, 32'd0);
        chk("t5_in_ready", 32'(In_Ready), 32'd1);
        drain();

        // Async reset while FULL, between edges
        Out_Ready = 1'b0;
        push_ab(20, -15);
        push_ab(-20, 15);
        chk("t6_full", 32'(In_Ready), 32'd0);
        #3;
        Reset = 1'b0;
        #1;
        chk("t6_out_valid", 32'(Out_Valid), 32'd0);
        chk("t6_in_ready", 32'(In_Ready), 32'd1);
        chk("t6_ovf_count", 32'(Ovf_Count), 32'd0);
        sb.delete();
        exp_count = 0;
        @(negedge Clk);
        Reset = 1'b1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("t6_no_stale", 32'(Out_Valid), 32'd0);
        end
        @(posedge Clk);
        #1;

        // Overflow counter saturation
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            push_ab(20, -15);
        end
        drain();
        chk("cnt_saturate", 32'(Ovf_Count), 32'(CNT_MAX));

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            push_ab(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
        end
        rand_ready = 1'b0;
        @(posedge Clk);
        #1;
        drain();
        chk("final_count", 32'(Ovf_Count), 32'(exp_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
